// File: rtl/fm_prenorm_if.sv
// Handshake bundle for fm_prenorm: operand in, normalized result out.
// The slave modport is the normalizer side, and the master modport is the producer/consumer side.
interface fm_prenorm_if #(
    parameter int WSIG = 24,
    parameter int WEXP = 10
);
    logic                   in_valid;
    logic                   in_ready;
    logic [WSIG-1:0]        in_sig;
    logic signed [WEXP-1:0] in_exp;
    logic                   out_valid;
    logic                   out_ready;
    logic [WSIG-1:0]        out_sig;
    logic signed [WEXP-1:0] out_exp;
    logic                   out_zero;
    logic                   out_clamped;

    modport master (
        output in_valid, in_sig, in_exp, out_ready,
        input  in_ready, out_valid, out_sig, out_exp, out_zero, out_clamped
    );

    modport slave (
        input  in_valid, in_sig, in_exp, out_ready,
        output in_ready, out_valid, out_sig, out_exp, out_zero, out_clamped
    );
endinterface

// File: rtl/fm_prenorm.sv
// Multi-cycle left-shift normalizer for subnormal significands ahead of the mantissa multiplier.
// Define PRENORM_FAST_LZC_EN to normalize in a single SHIFT cycle using a full-width leading-zero count.
module fm_prenorm #(
    parameter int WSIG = 24,
    parameter int WEXP = 10,
    parameter int STEP = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    fm_prenorm_if.slave  bus
);
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

    localparam logic [WEXP-1:0] EXPMIN = {1'b1, {(WEXP-1){1'b0}}};
    localparam logic [WEXP:0]   ONE    = {{WEXP{1'b0}}, 1'b1};
`ifdef PRENORM_FAST_LZC_EN
    localparam int LZ_SPAN = WSIG;
`else
    localparam int LZ_SPAN = STEP;
`endif

    state_t                 state, state_nx;
    logic [WSIG-1:0]        sig_r;
    logic signed [WEXP-1:0] exp_r;
    logic                   zero_r;
    logic                   clamped_r;

    logic [WEXP:0]          lz;
    logic [WEXP:0]          headroom;
    logic [WEXP:0]          k;
    logic [WSIG-1:0]        sig_shift;
    logic [WEXP:0]          exp_shift_w;
    logic                   hit_min;

    // Leading zeros within the top LZ_SPAN bits, saturating at LZ_SPAN.
    function automatic logic [WEXP:0] count_lz(input logic [WSIG-1:0] s);
        logic [WEXP:0] c;
        logic          found;
        c     = '0;
        found = 1'b0;
        for (int i = 0; i < LZ_SPAN; i++) begin
            if (!found) begin
                if (s[WSIG-1-i]) found = 1'b1;
                else             c     = c + ONE;
            end
        end
        return c;
    endfunction

    // Exponent arithmetic is done one bit wider so exp - EXPMIN never overflows.
    always_comb begin
        lz          = count_lz(sig_r);
        headroom    = {exp_r[WEXP-1], exp_r} - {1'b1, EXPMIN};
        k           = (lz < headroom) ? lz : headroom;
        sig_shift   = sig_r << k;
        exp_shift_w = {exp_r[WEXP-1], exp_r} - k;
        hit_min     = (exp_shift_w == {1'b1, EXPMIN});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:    if (bus.in_valid) state_nx = (bus.in_sig == '0) ? DONE : SHIFT;
            SHIFT:   if (sig_shift[WSIG-1] || hit_min) state_nx = DONE;
            DONE:    if (bus.out_ready) state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sig_r     <= '0;
            exp_r     <= '0;
            zero_r    <= 1'b0;
            clamped_r <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (bus.in_valid) begin
                        clamped_r <= 1'b0;
                        if (bus.in_sig == '0) begin
                            zero_r <= 1'b1;
                            sig_r  <= '0;
                            exp_r  <= '0;
                        end else begin
                            zero_r <= 1'b0;
                            sig_r  <= bus.in_sig;
                            exp_r  <= bus.in_exp;
                        end
                    end
                end
                SHIFT: begin
                    sig_r <= sig_shift;
                    exp_r <= exp_shift_w[WEXP-1:0];
                    if (!sig_shift[WSIG-1] && hit_min) clamped_r <= 1'b1;
                end
                default: ;
            endcase
        end
    end

    assign bus.in_ready    = (state == IDLE);
    assign bus.out_valid   = (state == DONE);
    assign bus.out_sig     = sig_r;
    assign bus.out_exp     = exp_r;
    assign bus.out_zero    = zero_r;
    assign bus.out_clamped = clamped_r;
endmodule

// File: tb/tb_fm_prenorm.sv
// Directed-vector bench for fm_prenorm: result table plus back-pressure and mid-operation reset sequences.
module tb_fm_prenorm;
    logic clk;
    logic rst_n;
    int   total;
    int   bad;

    fm_prenorm_if #(.WSIG(24), .WEXP(10)) bus ();

    fm_prenorm #(.WSIG(24), .WEXP(10), .STEP(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [23:0]       sig;
        logic signed [9:0] exp;
        int                lat;
        int                lat_fast;
        logic [23:0]       e_sig;
        logic signed [9:0] e_exp;
        logic              e_zero;
        logic              e_clamp;
    } vec_t;

    vec_t vecs[12];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    task automatic run_vec(input int idx);
        vec_t v;
        int   lat;
        int   want_lat;
        v = vecs[idx];
`ifdef PRENORM_FAST_LZC_EN
        want_lat = v.lat_fast;
`else
        want_lat = v.lat;
`endif
        @(negedge clk);
        chk($sformatf("v%0d in_ready_idle", idx), {31'b0, bus.in_ready}, 32'd1);
        bus.in_valid = 1'b1;
        bus.in_sig   = v.sig;
        bus.in_exp   = v.exp;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk($sformatf("v%0d latency", idx), lat, want_lat);
        chk($sformatf("v%0d out_sig", idx), {8'b0, bus.out_sig}, {8'b0, v.e_sig});
        chk($sformatf("v%0d out_exp", idx), {22'b0, bus.out_exp}, {22'b0, v.e_exp});
        chk($sformatf("v%0d out_zero", idx), {31'b0, bus.out_zero}, {31'b0, v.e_zero});
        chk($sformatf("v%0d out_clamped", idx), {31'b0, bus.out_clamped}, {31'b0, v.e_clamp});
        @(posedge clk);
        #1;
        chk($sformatf("v%0d in_ready_after", idx), {31'b0, bus.in_ready}, 32'd1);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout actual=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin
        int lat;
        int stale;
        total = 0;
        bad   = 0;

        vecs[0]  = '{24'h800000, 10'h005, 2, 2, 24'h800000, 10'h005, 1'b0, 1'b0};
        vecs[1]  = '{24'h000001, 10'h000, 7, 2, 24'h800000, 10'h3E9, 1'b0, 1'b0};
        vecs[2]  = '{24'h000000, 10'h007, 1, 1, 24'h000000, 10'h000, 1'b1, 1'b0};
        vecs[3]  = '{24'h000100, 10'h207, 3, 2, 24'h008000, 10'h200, 1'b0, 1'b1};
        vecs[4]  = '{24'h0F0000, 10'h003, 2, 2, 24'hF00000, 10'h3FF, 1'b0, 1'b0};
        vecs[5]  = '{24'h400000, 10'h200, 2, 2, 24'h400000, 10'h200, 1'b0, 1'b1};
        vecs[6]  = '{24'h000F00, 10'h00A, 4, 2, 24'hF00000, 10'h3FE, 1'b0, 1'b0};
        vecs[7]  = '{24'h7FFFFF, 10'h000, 2, 2, 24'hFFFFFE, 10'h3FF, 1'b0, 1'b0};
        vecs[8]  = '{24'h000001, 10'h202, 2, 2, 24'h000004, 10'h200, 1'b0, 1'b1};
        vecs[9]  = '{24'h000000, 10'h39C, 1, 1, 24'h000000, 10'h000, 1'b1, 1'b0};
        vecs[10] = '{24'h080000, 10'h1FF, 2, 2, 24'h800000, 10'h1FB, 1'b0, 1'b0};
        vecs[11] = '{24'h000003, 10'h216, 7, 2, 24'hC00000, 10'h200, 1'b0, 1'b0};

        rst_n         = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_sig    = '0;
        bus.in_exp    = '0;
        bus.out_ready = 1'b1;

        #12;
        chk("rst out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("rst out_sig", {8'b0, bus.out_sig}, 32'd0);
        chk("rst out_exp", {22'b0, bus.out_exp}, 32'd0);
        chk("rst out_zero", {31'b0, bus.out_zero}, 32'd0);
        chk("rst out_clamped", {31'b0, bus.out_clamped}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        chk("rst in_ready", {31'b0, bus.in_ready}, 32'd1);

        for (int i = 0; i < 12; i++) run_vec(i);

        // Back-pressure: result must hold while out_ready is low and new operands are ignored.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_sig    = 24'h0F0000;
        bus.in_exp    = 10'sd3;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        lat = 1;
        while (!bus.out_valid && lat < 40) begin
            @(posedge clk);
            #1;
            lat++;
        end
        chk("hold first_valid", {31'b0, bus.out_valid}, 32'd1);
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            bus.in_valid = 1'b1;
            bus.in_sig   = 24'h000001;
            bus.in_exp   = 10'sd0;
            @(posedge clk);
            #1;
            bus.in_valid = 1'b0;
            chk($sformatf("hold%0d out_valid", c), {31'b0, bus.out_valid}, 32'd1);
            chk($sformatf("hold%0d out_sig", c), {8'b0, bus.out_sig}, 32'h00F00000);
            chk($sformatf("hold%0d out_exp", c), {22'b0, bus.out_exp}, 32'h000003FF);
            chk($sformatf("hold%0d in_ready", c), {31'b0, bus.in_ready}, 32'd0);
        end
        @(negedge clk);
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        chk("hold release out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("hold release in_ready", {31'b0, bus.in_ready}, 32'd1);

        // Asynchronous reset during the third SHIFT cycle discards the operand.
        @(negedge clk);
        bus.in_valid = 1'b1;
        bus.in_sig   = 24'h000001;
        bus.in_exp   = 10'sd0;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst out_valid", {31'b0, bus.out_valid}, 32'd0);
        chk("midrst out_sig", {8'b0, bus.out_sig}, 32'd0);
        chk("midrst out_exp", {22'b0, bus.out_exp}, 32'd0);
        chk("midrst out_zero", {31'b0, bus.out_zero}, 32'd0);
        chk("midrst out_clamped", {31'b0, bus.out_clamped}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 10; c++) begin
            @(posedge clk);
            #1;
            if (bus.out_valid) stale++;
        end
        chk("midrst stale_valid", stale, 0);
        chk("midrst in_ready", {31'b0, bus.in_ready}, 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fm_prenorm.md
Name: fm_prenorm

Overview:
Left-shift normalizer for subnormal or unnormalized significands, the inverse of the multiplier's post-product denormalizing right shift. It accepts a significand and a signed exponent, shifts the significand left until the MSB (hidden-bit position) is 1, and decrements the exponent by the shift amount. It is multi-cycle, shifting at most STEP bits per cycle, with valid/ready handshakes on both sides. It sits ahead of the mantissa multiplier and prenormalizes subnormal operands.

Parameters:
WSIG, 24, significand width including the hidden bit
WEXP, 10, signed two's-complement exponent width
STEP, 4, maximum left shift per cycle; power of 2, 1..WSIG

Ports:
clk  input  1  clock; all state updates on the rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  input operand valid
in_ready  output  1  block can accept an operand
in_sig  input  WSIG  input significand
in_exp  input  WEXP  input exponent, signed
out_valid  output  1  result valid
out_ready  input  1  consumer accepts the result
out_sig  output  WSIG  normalized significand
out_exp  output  WEXP  adjusted exponent, signed
out_zero  output  1  input significand was all zeros
out_clamped  output  1  normalization stopped at EXPMIN before the MSB reached 1

Behaviour:
- Reset and clock: one clock; reset is asynchronous and active-low (clk, rst_n).
- State after reset:
  - State IDLE.
  - Registers sig, exp, zero and clamped all cleared, so out_sig=0, out_exp=0, out_zero=0, out_clamped=0, out_valid=0.
  - in_ready=1 after rst_n deasserts.
- EXPMIN = -2^(WEXP-1) (-512 at the default width).
- States are IDLE, SHIFT and DONE. in_ready = (state==IDLE). out_valid = (state==DONE).
- IDLE, on in_valid=1:
  - Register in_sig and in_exp; clear clamped.
  - If in_sig==0: zero=1, sig=0, exp=0, next state DONE.
  - Otherwise: zero=0, next state SHIFT.
- SHIFT, each cycle:
  - lz = number of leading zeros among the top STEP bits of sig (value 0..STEP).
  - k = min(lz, exp - EXPMIN). Compute the difference at WEXP+1 bits so it cannot overflow.
  - sig <= sig << k (zero fill); exp <= exp - k.
  - Go to DONE when the shifted MSB is 1, or when exp - k == EXPMIN while the MSB is still 0. In the second case set clamped=1.
  - Otherwise stay in SHIFT.
  - A left shift is lossless; no sticky or loss output exists.
- Number of SHIFT cycles:
  - Nonzero input with lz0 total leading zeros and no clamp: max(1, ceil(lz0/STEP)).
  - An already-normalized input still spends exactly 1 SHIFT cycle (k=0).
- Latency (accept edge to out_valid):
  - Nonzero input: 1 + SHIFT cycles.
  - Zero input: 1 cycle.
- DONE:
  - out_valid held at 1; out_sig, out_exp, out_zero and out_clamped held stable until out_valid & out_ready.
  - On that handshake, go to IDLE.
  - A new operand is never accepted in the same cycle as the output handshake; the minimum issue interval is 3 cycles.
- in_valid is ignored outside IDLE; in_sig/in_exp are sampled only at acceptance.
- Asserting rst_n mid-operation immediately (asynchronously) returns to IDLE and clears all outputs. The in-flight operand is discarded, with no output.

Optional Feature:
PRENORM_FAST_LZC_EN
- Defined: SHIFT uses a full-width leading-zero count in place of the top-STEP-bit count. k = min(lz0, exp - EXPMIN). Every nonzero operand takes exactly 1 SHIFT cycle, so latency is 2 cycles. Results are identical to the iterative mode. STEP is unused.
- Undefined: iterative STEP-bit behaviour as described above.

Test Plan:
- in_sig=24'h800000, in_exp=5 -> out_valid 2 cycles after accept; out_sig=24'h800000, out_exp=5, out_zero=0, out_clamped=0.
- in_sig=24'h000001, in_exp=0 -> 6 SHIFT cycles, out_valid at cycle 7; out_sig=24'h800000, out_exp=-23 (10'h3E9). With PRENORM_FAST_LZC_EN: same result at cycle 2.
- in_sig=0, in_exp=7 -> out_valid 1 cycle after accept; out_zero=1, out_sig=0, out_exp=0.
- in_sig=24'h000100 (lz0=15), in_exp=-505 -> shift 7; out_sig=24'h008000, out_exp=-512 (10'h200), out_clamped=1.
- in_sig=24'h0F0000, in_exp=3, out_ready held 0 for 5 cycles -> out_sig=24'hF00000 and out_exp=-1 stay stable; in_ready=0 and in_valid pulses are ignored. Raise out_ready -> handshake, then in_ready=1 on the next cycle.
- in_sig=24'h000001 accepted, then rst_n=0 on the 3rd SHIFT cycle -> out_valid=0 and all outputs 0 immediately. After release: in_ready=1, and no stale result appears.
